// File: rtl/mont_pkg.sv
// Shared types and defaults for the bit-serial Montgomery iteration controller.
// The optional abort path is enabled by defining MONT_ABORT_EN.
package mont_pkg;

    localparam int unsigned WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ITER  = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mont_iter_ctrl_if.sv
// Control/status bundle between the Montgomery controller and its datapath.
// The abort/aborted pair exists only when MONT_ABORT_EN is defined.
interface mont_iter_ctrl_if #(
    parameter int unsigned WIDTH = mont_pkg::WIDTH_DEF,
    parameter int unsigned CNT_W = $clog2(WIDTH)
);
    logic             start;
    logic             a_bit;
    logic             b0;
    logic             s0;
    logic             ge_m;
    logic             busy;
    logic             load_en;
    logic             sel_b;
    logic             sel_m;
    logic             acc_en;
    logic             shift_a;
    logic             sub_sel;
    logic             out_en;
    logic             done;
    logic [CNT_W-1:0] iter_idx;
`ifdef MONT_ABORT_EN
    logic             abort;
    logic             aborted;

    modport master (
        output start, a_bit, b0, s0, ge_m, abort,
        input  busy, load_en, sel_b, sel_m, acc_en, shift_a, sub_sel, out_en, done, iter_idx,
               aborted
    );
    modport slave (
        input  start, a_bit, b0, s0, ge_m, abort,
        output busy, load_en, sel_b, sel_m, acc_en, shift_a, sub_sel, out_en, done, iter_idx,
               aborted
    );
`else
    modport master (
        output start, a_bit, b0, s0, ge_m,
        input  busy, load_en, sel_b, sel_m, acc_en, shift_a, sub_sel, out_en, done, iter_idx
    );
    modport slave (
        input  start, a_bit, b0, s0, ge_m,
        output busy, load_en, sel_b, sel_m, acc_en, shift_a, sub_sel, out_en, done, iter_idx
    );
`endif
endinterface

// File: rtl/mont_iter_counter.sv
// Iteration index counter with synchronous clear/enable and a terminal flag.
module mont_iter_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign last = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mont_iter_ctrl.sv
// Sequencer for the radix-2 bit-serial Montgomery multiplier datapath.
// Define MONT_ABORT_EN to add the abort input and aborted pulse.
module mont_iter_ctrl
    import mont_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    mont_iter_ctrl_if.slave  bus
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic             last;
    logic             abort_req;
    logic             busy_q, load_en_q, acc_en_q, out_en_q, done_q;
    logic             busy_d, load_en_d, acc_en_d, out_en_d, done_d;

`ifdef MONT_ABORT_EN
    logic aborted_q;
    assign abort_req   = bus.abort && (state inside {LOAD, ITER, FINAL});
    assign bus.aborted = aborted_q;
`else
    assign abort_req   = 1'b0;
`endif

    // Counter is held at zero everywhere except while iterating.
    mont_iter_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   ((state != ITER) || last || abort_req),
        .en    (state == ITER),
        .count (count),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            load_en_q <= 1'b0;
            acc_en_q  <= 1'b0;
            out_en_q  <= 1'b0;
            done_q    <= 1'b0;
`ifdef MONT_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            busy_q    <= busy_d;
            load_en_q <= load_en_d;
            acc_en_q  <= acc_en_d;
            out_en_q  <= out_en_d;
            done_q    <= done_d;
`ifdef MONT_ABORT_EN
            aborted_q <= abort_req;
`endif
        end
    end

    // Registered strobes are decoded from the next state so they align with it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = LOAD;
            LOAD:    state_nxt = ITER;
            ITER:    if (last) state_nxt = FINAL;
            FINAL:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort_req) state_nxt = IDLE;

        busy_d    = (state_nxt != IDLE);
        load_en_d = (state_nxt == LOAD);
        acc_en_d  = (state_nxt == ITER);
        out_en_d  = (state_nxt == FINAL);
        done_d    = (state_nxt == DONE);
    end

    assign bus.busy     = busy_q;
    assign bus.load_en  = load_en_q;
    assign bus.acc_en   = acc_en_q;
    assign bus.shift_a  = acc_en_q;
    assign bus.out_en   = out_en_q;
    assign bus.done     = done_q;
    assign bus.iter_idx = count;

    // Mux selects follow the live datapath bits within the current cycle.
    assign bus.sel_b   = (state == ITER) && bus.a_bit;
    assign bus.sel_m   = (state == ITER) && (bus.s0 ^ (bus.a_bit && bus.b0));
    assign bus.sub_sel = (state == FINAL) && bus.ge_m;

endmodule

// File: tb/tb_mont_iter_ctrl.sv
// Directed bench for mont_iter_ctrl (WIDTH=4) with a behavioural Montgomery datapath.
// Exercises the abort path when MONT_ABORT_EN is defined.
module tb_mont_iter_ctrl;
    import mont_pkg::*;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = 2;

    logic clk = 1'b0;
    logic rst;
    logic start;
    always #5 clk = ~clk;

    mont_iter_ctrl_if #(.WIDTH(W), .CNT_W(CW)) bus ();
    mont_iter_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Behavioural datapath: A/B/M/S registers driven by the controller strobes.
    logic [7:0] ra, rb, rm, rs, res;
    logic [7:0] op_a, op_b, op_m;
    logic       ovr, a_o, b_o, s_o;
    logic       ge_ovr, ge_o;

    always @(posedge clk) begin
        if (bus.load_en) begin
            ra <= op_a;
            rb <= op_b;
            rm <= op_m;
            rs <= 8'd0;
        end else begin
            if (bus.acc_en) rs <= 8'(rs + (bus.sel_b ? rb : 8'd0) + (bus.sel_m ? rm : 8'd0)) >> 1;
            if (bus.shift_a) ra <= ra >> 1;
        end
        if (bus.out_en) res <= bus.sub_sel ? 8'(rs - rm) : rs;
    end

    assign bus.start = start;
    assign bus.a_bit = ovr ? a_o : ra[0];
    assign bus.b0    = ovr ? b_o : rb[0];
    assign bus.s0    = ovr ? s_o : rs[0];
    assign bus.ge_m  = ge_ovr ? ge_o : (rs >= rm);

`ifdef MONT_ABORT_EN
    logic abort;
    assign bus.abort = abort;
`endif

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Waits (bounded) for a strobe: 0=acc_en 1=out_en 2=done; returns at that negedge.
    task automatic wait_sig(input int which, input string nm);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < 20 && !hit; n++) begin
            @(negedge clk);
            start = 1'b0;
            case (which)
                0:       hit = bus.acc_en;
                1:       hit = bus.out_en;
                2:       hit = bus.done;
                default: hit = 1'b0;
            endcase
        end
        if (!hit) chk({nm, " timeout"}, 0, 1);
    endtask

    function automatic int outs_or();
        return int'(bus.busy | bus.load_en | bus.sel_b | bus.sel_m | bus.acc_en | bus.shift_a |
                    bus.sub_sel | bus.out_en | bus.done | (|bus.iter_idx));
    endfunction

    // Full 7*11 mod 13 multiply; called at an IDLE-cycle negedge.
    task automatic run_mult(input string tag);
        int acc, dcyc;
        acc  = 0;
        dcyc = -1;
        op_a = 8'd7; op_b = 8'd11; op_m = 8'd13;
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 20 && dcyc < 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 1) chk({tag, " load_en c1"}, int'(bus.load_en), 1);
            if (bus.acc_en) begin
                chk({tag, " iter_idx"}, int'(bus.iter_idx), k - 2);
                acc++;
            end
            if (bus.done) dcyc = k;
        end
        chk({tag, " done cycle"}, dcyc, 7);
        chk({tag, " acc_en count"}, acc, 4);
        chk({tag, " result"}, int'(res), 4);
        @(negedge clk);
    endtask

    typedef struct packed {
        logic a;
        logic b;
        logic s;
        logic eb;
        logic em;
    } sel_vec_t;

    sel_vec_t vt [6];

    initial begin
        int loads, cnt;
        bit hit;

        vt[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vt[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        rst = 1'b1; start = 1'b0; ovr = 1'b0; a_o = 1'b0; b_o = 1'b0; s_o = 1'b0;
        ge_ovr = 1'b0; ge_o = 1'b0;
        op_a = 8'd0; op_b = 8'd0; op_m = 8'd0;
`ifdef MONT_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("reset outputs", outs_or(), 0);

        // rst and start together: rst wins
        start = 1'b1;
        @(negedge clk);
        chk("rst+start busy", int'(bus.busy), 0);
        chk("rst+start load_en", int'(bus.load_en), 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("idle outputs", outs_or(), 0);

        run_mult("mult1");

        // Select decode vectors applied live during an ITER cycle.
        for (int i = 0; i < 6; i++) begin
            op_a = 8'd5; op_b = 8'd3; op_m = 8'd11;
            start = 1'b1;
            wait_sig(0, "sel reach iter");
            ovr = 1'b1; a_o = vt[i].a; b_o = vt[i].b; s_o = vt[i].s;
            #1;
            chk($sformatf("sel_b vec%0d", i), int'(bus.sel_b), int'(vt[i].eb));
            chk($sformatf("sel_m vec%0d", i), int'(bus.sel_m), int'(vt[i].em));
            ovr = 1'b0;
            wait_sig(2, "sel done");
            @(negedge clk);
        end

        // Final conditional subtraction follows ge_m within FINAL.
        start = 1'b1;
        wait_sig(1, "final reach");
        ge_ovr = 1'b1; ge_o = 1'b1;
        #1;
        chk("final sub_sel ge=1", int'(bus.sub_sel), 1);
        chk("final out_en", int'(bus.out_en), 1);
        ge_o = 1'b0;
        #1;
        chk("final sub_sel ge=0", int'(bus.sub_sel), 0);
        ge_ovr = 1'b0;
        wait_sig(2, "final done");
        @(negedge clk);

        // start held high: one LOAD per operation, next only after IDLE.
        loads = 0;
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k <= 8 && bus.load_en) loads++;
            if (k == 7) chk("held done c7", int'(bus.done), 1);
            if (k == 8) chk("held busy c8", int'(bus.busy), 0);
            if (k == 9) chk("held load c9", int'(bus.load_en), 1);
        end
        chk("held loads", loads, 1);
        start = 1'b0;
        wait_sig(2, "held done2");
        @(negedge clk);

        // Reset at iteration 2.
        op_a = 8'd7; op_b = 8'd11; op_m = 8'd13;
        start = 1'b1;
        hit = 1'b0;
        for (int n = 0; n < 20 && !hit; n++) begin
            @(negedge clk);
            start = 1'b0;
            hit = bus.acc_en && (bus.iter_idx == 2'd2);
        end
        chk("reach iter2", int'(hit), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst busy", int'(bus.busy), 0);
        chk("rst iter_idx", int'(bus.iter_idx), 0);
        chk("rst outputs", outs_or(), 0);
        cnt = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.done || bus.out_en || bus.busy) cnt++;
        end
        chk("no activity after rst", cnt, 0);
        run_mult("after rst");

`ifdef MONT_ABORT_EN
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort idle ignored", int'(bus.aborted), 0);
        start = 1'b1;
        hit = 1'b0;
        for (int n = 0; n < 20 && !hit; n++) begin
            @(negedge clk);
            start = 1'b0;
            hit = bus.acc_en && (bus.iter_idx == 2'd1);
        end
        chk("reach iter1", int'(hit), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("aborted pulse", int'(bus.aborted), 1);
        chk("abort busy", int'(bus.busy), 0);
        chk("abort iter_idx", int'(bus.iter_idx), 0);
        @(negedge clk);
        chk("aborted one cycle", int'(bus.aborted), 0);
        cnt = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.done || bus.out_en) cnt++;
        end
        chk("no done after abort", cnt, 0);
        run_mult("after abort");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
